arb_cycle_extractor: RTL and testbench
======================================

Name: arb_cycle_extractor

Overview:
- Downstream consumer of the Bellman-Ford relaxation stage. Starts after `bellman_done`.
- Runs one extra relaxation check over the whole adjacency matrix to detect a negative cycle, i.e. an arbitrage opportunity.
- If a cycle exists, walks the predecessor chain to land inside the cycle, then streams the cycle's vertex IDs to the order-generation logic over a valid/ready handshake.
- Read-only on vertmat and adjmat; it never writes either memory.

Parameters:
- NODES, 4: vertex count; indices run 0..NODES-1.
- PRED_W, 8: vertex index width; vertmat word bits [PRED_W+WEIGHT_W-1:WEIGHT_W] hold the predecessor.
- WEIGHT_W, 32: signed weight width; vertmat word bits [WEIGHT_W-1:0] hold the distance.
- INF, 32'h777fffff: unreachable-distance sentinel.

Ports:
- clk  in  1  clock
- cycle_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run (tied to the Bellman done rising edge)
- vertmat_addr_a  out  PRED_W  source-vertex read address
- vertmat_addr_b  out  PRED_W  dest-vertex / walk read address
- vertmat_q_a  in  PRED_W+WEIGHT_W  read data, one cycle after the address
- vertmat_q_b  in  PRED_W+WEIGHT_W  read data, one cycle after the address
- adjmat_row_addr  out  PRED_W  edge row (source)
- adjmat_col_addr  out  PRED_W  edge column (dest)
- adjmat_q  in  WEIGHT_W  signed edge weight, one-cycle latency; 0 = no edge
- out_vertex  out  PRED_W  cycle vertex ID
- out_valid  out  1  out_vertex valid
- out_ready  in  1  consumer accepts
- out_last  out  1  marks the final vertex of the cycle
- cycle_found  out  1  negative cycle detected; held until the next start or reset
- cycle_len  out  PRED_W+1  number of vertices emitted
- error  out  1  trace exceeded NODES steps
- done  out  1  run complete; held until the next start or reset

Behaviour:
- Reset values: all addresses 0, out_* 0, cycle_found 0, cycle_len 0, error 0, done 0; state = IDLE.
- Reset asserted mid-run aborts the run at once. No partial output beat survives.
- States:
  - IDLE: wait for start. On start, clear done, cycle_found, error and cycle_len; i=0, j=0; go to SCAN_RD.
  - SCAN_RD: drive vertmat_addr_a=i, vertmat_addr_b=j, adjmat_row=i, adjmat_col=j; go to SCAN_CHK.
  - SCAN_CHK: compute svw=q_a weight, dvw=q_b weight, e=adjmat_q.
    - Edge relaxes if e!=0, svw!=INF, i!=j and (svw+e) < dvw.
    - The sum is computed at WEIGHT_W+1 bits signed, so no overflow wrap.
    - If it relaxes: v=j, cycle_found=1, go to WALK_RD.
    - Else if i==NODES-1 and j==NODES-1: go to DONE with cycle_found=0.
    - Else advance j, wrapping to 0 and incrementing i; go to SCAN_RD.
    - Each edge takes exactly 2 cycles.
  - WALK_RD / WALK_LAT: vertmat_addr_b=v, then v=pred(q_b). Repeat exactly NODES times so v is guaranteed on the cycle. Then s=v, go to TRACE_RD.
  - TRACE_RD: vertmat_addr_b=v; go to TRACE_EMIT.
  - TRACE_EMIT:
    - Present out_vertex=v, out_valid=1, out_last=(pred(q_b)==s).
    - Hold out_vertex, out_valid and out_last stable until out_ready=1.
    - On handshake: cycle_len++, v=pred.
    - If out_last was set, go to DONE. Otherwise go to TRACE_RD.
    - If cycle_len would exceed NODES: set error=1, drop out_valid, go to DONE.
  - DONE: done=1. A new start restarts the run; otherwise stay in DONE.
- start while not in IDLE/DONE is ignored.
- The emitted sequence is in predecessor order, i.e. reverse trade order. The consumer reverses it.
- A self-loop (i==j) is never treated as a cycle.

Optional Feature:
- Macro: CYCLE_PROFIT_EN.
- With it defined:
  - Extra port cycle_weight, out, signed WEIGHT_W+PRED_W bits.
  - Accumulates adjmat weight (pred->v) for each emitted vertex. Each weight fetch adds one cycle per emission via adjmat_row=pred, adjmat_col=v.
  - Valid when done=1 and cycle_found=1; reset to 0.
- Without it: no port, no accumulator, and adjmat is idle after the scan.

Test Plan:
- No edges (all adjmat 0), NODES=4 -> done after 32 cycles in scan, cycle_found=0, out_valid never asserted.
- Vertmat dist {0,5,3,INF}, preds consistent, edges nonnegative -> cycle_found=0, done=1, error=0.
- Cycle 1->2->3->1 with weights -1,-1,-1; vertmat holding its final pass values -> emits 3 beats with out_last on the 3rd, cycle_len=3; the set {1,2,3} appears in predecessor order.
- Same cycle with out_ready low for 5 cycles on beat 2 -> out_vertex stable, no duplicate or lost beat, cycle_len=3.
- Corrupt pred chain that never returns to s -> error=1 after NODES beats, done=1.
- cycle_reset asserted during TRACE_EMIT -> next cycle out_valid=0, done=0, state IDLE; a new start reruns cleanly. With CYCLE_PROFIT_EN, the 3-cycle case gives cycle_weight=-3.

Source files
------------

// File: rtl/arb_cycle_extractor.sv
// Negative-cycle detector and cycle tracer that runs after the Bellman-Ford relaxation stage.
// Optional feature macro: CYCLE_PROFIT_EN (adds the cycle_weight accumulator and port).
module arb_cycle_extractor #(
    parameter int                    NODES    = 4,
    parameter int                    PRED_W   = 8,
    parameter int                    WEIGHT_W = 32,
    parameter logic [WEIGHT_W-1:0]   INF      = 32'h777fffff
) (
    input  logic                          clk,
    input  logic                          cycle_reset,
    input  logic                          start,
    output logic [PRED_W-1:0]             vertmat_addr_a,
    output logic [PRED_W-1:0]             vertmat_addr_b,
    input  logic [PRED_W+WEIGHT_W-1:0]    vertmat_q_a,
    input  logic [PRED_W+WEIGHT_W-1:0]    vertmat_q_b,
    output logic [PRED_W-1:0]             adjmat_row_addr,
    output logic [PRED_W-1:0]             adjmat_col_addr,
    input  logic [WEIGHT_W-1:0]           adjmat_q,
    output logic [PRED_W-1:0]             out_vertex,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          cycle_found,
    output logic [PRED_W:0]               cycle_len,
    output logic                          error,
    output logic                          done
`ifdef CYCLE_PROFIT_EN
    ,
    output logic signed [WEIGHT_W+PRED_W-1:0] cycle_weight
`endif
);

    localparam int VW = PRED_W + WEIGHT_W;
    localparam int LW = PRED_W + 1;
    localparam logic [PRED_W-1:0] LAST_IDX = PRED_W'(NODES - 1);
    localparam logic [LW-1:0]     NODES_LW = LW'(NODES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN_RD,
        S_SCAN_CHK,
        S_WALK_RD,
        S_WALK_LAT,
        S_TRACE_RD,
        S_TRACE_EMIT,
        S_DONE
`ifdef CYCLE_PROFIT_EN
        ,
        S_PROFIT_ACC
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [PRED_W-1:0]   i_q, i_d;
    logic [PRED_W-1:0]   j_q, j_d;
    logic [PRED_W-1:0]   v_q, v_d;
    logic [PRED_W-1:0]   s_q, s_d;
    logic [LW-1:0]       walk_q, walk_d;
    logic [LW-1:0]       cycle_len_q, cycle_len_d;
    logic                cycle_found_q, cycle_found_d;
    logic                error_q, error_d;
`ifdef CYCLE_PROFIT_EN
    logic signed [WEIGHT_W+PRED_W-1:0] weight_q, weight_d;
    logic                              last_q, last_d;
`endif

    logic [PRED_W-1:0]          pred_b;
    logic [WEIGHT_W-1:0]        svw, dvw, edge_w;
    logic signed [WEIGHT_W:0]   relax_sum, dvw_ext;
    logic                       relaxes;
    logic                       unused_pred_a;

    // The predecessor field of port A is never needed; only its distance is.
    assign unused_pred_a = ^vertmat_q_a[VW-1:WEIGHT_W];

    assign pred_b  = vertmat_q_b[VW-1:WEIGHT_W];
    assign svw     = vertmat_q_a[WEIGHT_W-1:0];
    assign dvw     = vertmat_q_b[WEIGHT_W-1:0];
    assign edge_w  = adjmat_q;

    // One extra bit of headroom keeps svw+e from wrapping into a false relaxation.
    always_comb begin
        relax_sum = {svw[WEIGHT_W-1], svw} + {edge_w[WEIGHT_W-1], edge_w};
        dvw_ext   = {dvw[WEIGHT_W-1], dvw};
        relaxes   = (edge_w != '0) && (svw != INF) && (i_q != j_q) && (relax_sum < dvw_ext);
    end

    always_comb begin
        state_d         = state_q;
        i_d             = i_q;
        j_d             = j_q;
        v_d             = v_q;
        s_d             = s_q;
        walk_d          = walk_q;
        cycle_len_d     = cycle_len_q;
        cycle_found_d   = cycle_found_q;
        error_d         = error_q;
`ifdef CYCLE_PROFIT_EN
        weight_d        = weight_q;
        last_d          = last_q;
`endif
        vertmat_addr_a  = '0;
        vertmat_addr_b  = '0;
        adjmat_row_addr = '0;
        adjmat_col_addr = '0;
        out_vertex      = '0;
        out_valid       = 1'b0;
        out_last        = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_SCAN_RD;
                    i_d           = '0;
                    j_d           = '0;
                    cycle_found_d = 1'b0;
                    error_d       = 1'b0;
                    cycle_len_d   = '0;
`ifdef CYCLE_PROFIT_EN
                    weight_d      = '0;
`endif
                end
            end

            S_SCAN_RD: begin
                vertmat_addr_a  = i_q;
                vertmat_addr_b  = j_q;
                adjmat_row_addr = i_q;
                adjmat_col_addr = j_q;
                state_d         = S_SCAN_CHK;
            end

            S_SCAN_CHK: begin
                if (relaxes) begin
                    v_d           = j_q;
                    cycle_found_d = 1'b1;
                    walk_d        = '0;
                    state_d       = S_WALK_RD;
                end else if (i_q == LAST_IDX && j_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    if (j_q == LAST_IDX) begin
                        j_d = '0;
                        i_d = i_q + PRED_W'(1);
                    end else begin
                        j_d = j_q + PRED_W'(1);
                    end
                    state_d = S_SCAN_RD;
                end
            end

            S_WALK_RD: begin
                vertmat_addr_b = v_q;
                state_d        = S_WALK_LAT;
            end

            // NODES predecessor hops from any vertex are enough to land on the cycle itself.
            S_WALK_LAT: begin
                v_d    = pred_b;
                walk_d = walk_q + LW'(1);
                if (walk_q == NODES_LW - LW'(1)) begin
                    s_d     = pred_b;
                    state_d = S_TRACE_RD;
                end else begin
                    state_d = S_WALK_RD;
                end
            end

            S_TRACE_RD: begin
                vertmat_addr_b = v_q;
                state_d        = S_TRACE_EMIT;
            end

            // Address stays on v so pred_b, and therefore out_last, hold steady through a stall.
            S_TRACE_EMIT: begin
                vertmat_addr_b = v_q;
                if (cycle_len_q >= NODES_LW) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    out_vertex = v_q;
                    out_valid  = 1'b1;
                    out_last   = (pred_b == s_q);
`ifdef CYCLE_PROFIT_EN
                    adjmat_row_addr = pred_b;
                    adjmat_col_addr = v_q;
`endif
                    if (out_ready) begin
                        cycle_len_d = cycle_len_q + LW'(1);
                        v_d         = pred_b;
`ifdef CYCLE_PROFIT_EN
                        last_d      = out_last;
                        state_d     = S_PROFIT_ACC;
`else
                        state_d     = out_last ? S_DONE : S_TRACE_RD;
`endif
                    end
                end
            end

`ifdef CYCLE_PROFIT_EN
            S_PROFIT_ACC: begin
                weight_d = weight_q + {{PRED_W{adjmat_q[WEIGHT_W-1]}}, adjmat_q};
                state_d  = last_q ? S_DONE : S_TRACE_RD;
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cycle_reset) begin
            state_q       <= S_IDLE;
            i_q           <= '0;
            j_q           <= '0;
            v_q           <= '0;
            s_q           <= '0;
            walk_q        <= '0;
            cycle_len_q   <= '0;
            cycle_found_q <= 1'b0;
            error_q       <= 1'b0;
`ifdef CYCLE_PROFIT_EN
            weight_q      <= '0;
            last_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            v_q           <= v_d;
            s_q           <= s_d;
            walk_q        <= walk_d;
            cycle_len_q   <= cycle_len_d;
            cycle_found_q <= cycle_found_d;
            error_q       <= error_d;
`ifdef CYCLE_PROFIT_EN
            weight_q      <= weight_d;
            last_q        <= last_d;
`endif
        end
    end

    assign cycle_found = cycle_found_q;
    assign cycle_len   = cycle_len_q;
    assign error       = error_q;
    assign done        = (state_q == S_DONE);
`ifdef CYCLE_PROFIT_EN
    assign cycle_weight = weight_q;
`endif

endmodule

// File: tb/tb_arb_cycle_extractor.sv
// Directed bench for arb_cycle_extractor: behavioural vertmat/adjmat memories and hand-computed expectations.
module tb_arb_cycle_extractor;

    localparam logic [31:0] INF_W = 32'h777fffff;

    logic        clk;
    logic        cycle_reset;
    logic        start;
    logic [7:0]  vertmat_addr_a, vertmat_addr_b;
    logic [39:0] vertmat_q_a, vertmat_q_b;
    logic [7:0]  adjmat_row_addr, adjmat_col_addr;
    logic [31:0] adjmat_q;
    logic [7:0]  out_vertex;
    logic        out_valid, out_ready, out_last;
    logic        cycle_found;
    logic [8:0]  cycle_len;
    logic        error, done;
`ifdef CYCLE_PROFIT_EN
    logic signed [39:0] cycle_weight;
`endif

    logic [39:0] vmem [0:255];
    logic [31:0] amem [0:3][0:3];

    int check_count = 0;
    int err_count   = 0;

    logic [7:0] beat_v    [0:15];
    logic       beat_last [0:15];
    int         nbeats;
    bit         saw_valid;
    bit         timed_out;
    int         done_cycles;

    arb_cycle_extractor dut (
        .clk             (clk),
        .cycle_reset     (cycle_reset),
        .start           (start),
        .vertmat_addr_a  (vertmat_addr_a),
        .vertmat_addr_b  (vertmat_addr_b),
        .vertmat_q_a     (vertmat_q_a),
        .vertmat_q_b     (vertmat_q_b),
        .adjmat_row_addr (adjmat_row_addr),
        .adjmat_col_addr (adjmat_col_addr),
        .adjmat_q        (adjmat_q),
        .out_vertex      (out_vertex),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .cycle_found     (cycle_found),
        .cycle_len       (cycle_len),
        .error           (error),
        .done            (done)
`ifdef CYCLE_PROFIT_EN
        ,
        .cycle_weight    (cycle_weight)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        vertmat_q_a <= vmem[vertmat_addr_a];
        vertmat_q_b <= vmem[vertmat_addr_b];
        if (adjmat_row_addr < 8'd4 && adjmat_col_addr < 8'd4)
            adjmat_q <= amem[adjmat_row_addr[1:0]][adjmat_col_addr[1:0]];
        else
            adjmat_q <= 32'd0;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setVert(input int idx, input logic [7:0] p, input logic [31:0] d);
        vmem[idx] = {p, d};
    endtask

    task automatic clearMem(input bit chain_preds);
        for (int k = 0; k < 256; k++)
            vmem[k] = {chain_preds ? 8'(k + 1) : 8'(k), 32'd0};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                amem[r][c] = 32'd0;
    endtask

    // Cycle 1->2->3->1 with -1 edges, distances as left by the last relaxation pass.
    task automatic loadCycleGraph(input bit corrupt_preds);
        clearMem(corrupt_preds);
        setVert(0, corrupt_preds ? 8'd1 : 8'd0, 32'd0);
        setVert(1, corrupt_preds ? 8'd2 : 8'd3, -32'sd2);
        setVert(2, corrupt_preds ? 8'd3 : 8'd1, -32'sd3);
        setVert(3, corrupt_preds ? 8'd4 : 8'd2, -32'sd4);
        amem[0][1] = 32'd1;
        amem[1][2] = -32'sd1;
        amem[2][3] = -32'sd1;
        amem[3][1] = -32'sd1;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_clears_done", done, 1'b0);
        checkOutput("start_clears_found", cycle_found, 1'b0);
    endtask

    task automatic runAndCollect(input int stall_beat, input int stall_len, input bit poke_start, input int budget);
        int         stall_left;
        bit         have_held;
        logic [7:0] held_vertex;
        nbeats      = 0;
        saw_valid   = 0;
        timed_out   = 1;
        done_cycles = 0;
        stall_left  = stall_len;
        have_held   = 0;
        held_vertex = '0;
        applyStimulus();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                timed_out   = 0;
                done_cycles = c + 1;
                break;
            end
            if (out_valid) begin
                saw_valid = 1;
                if (nbeats == stall_beat && stall_left > 0) begin
                    out_ready = 1'b0;
                    if (have_held)
                        checkOutput("stall_vertex_hold", out_vertex, held_vertex);
                    held_vertex = out_vertex;
                    have_held   = 1;
                    stall_left--;
                    if (poke_start && stall_left == 2)
                        start = 1'b1;
                end else begin
                    out_ready = 1'b1;
                    if (nbeats < 16) begin
                        beat_v[nbeats]    = out_vertex;
                        beat_last[nbeats] = out_last;
                    end
                    nbeats++;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
        out_ready = 1'b0;
        start     = 1'b0;
        checkOutput("run_timeout", timed_out, 1'b0);
    endtask

    task automatic checkCycleRun(input string pfx);
        checkOutput({pfx, "_beats"}, nbeats, 3);
        checkOutput({pfx, "_v0"}, beat_v[0], 8'd3);
        checkOutput({pfx, "_v1"}, beat_v[1], 8'd2);
        checkOutput({pfx, "_v2"}, beat_v[2], 8'd1);
        checkOutput({pfx, "_last0"}, beat_last[0], 1'b0);
        checkOutput({pfx, "_last1"}, beat_last[1], 1'b0);
        checkOutput({pfx, "_last2"}, beat_last[2], 1'b1);
        checkOutput({pfx, "_len"}, cycle_len, 9'd3);
        checkOutput({pfx, "_found"}, cycle_found, 1'b1);
        checkOutput({pfx, "_error"}, error, 1'b0);
        checkOutput({pfx, "_done"}, done, 1'b1);
`ifdef CYCLE_PROFIT_EN
        checkOutput({pfx, "_weight"}, cycle_weight, -64'sd3);
`endif
    endtask

    initial begin
        bit reached;
        cycle_reset = 1'b1;
        start       = 1'b0;
        out_ready   = 1'b0;
        clearMem(0);
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_last", out_last, 1'b0);
        checkOutput("rst_vertex", out_vertex, 8'd0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_found", cycle_found, 1'b0);
        checkOutput("rst_len", cycle_len, 9'd0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_addr_a", vertmat_addr_a, 8'd0);
        checkOutput("rst_addr_b", vertmat_addr_b, 8'd0);
        checkOutput("rst_row", adjmat_row_addr, 8'd0);
        checkOutput("rst_col", adjmat_col_addr, 8'd0);
        cycle_reset = 1'b0;

        $display("[TB] no-edge graph");
        clearMem(0);
        runAndCollect(-1, 0, 0, 200);
        checkOutput("noedge_scan_cycles", done_cycles, 32);
        checkOutput("noedge_found", cycle_found, 1'b0);
        checkOutput("noedge_valid_seen", saw_valid, 1'b0);
        checkOutput("noedge_error", error, 1'b0);

        // INF source with a huge negative edge and a near-overflow positive edge must not relax.
        $display("[TB] consistent graph, no negative cycle");
        clearMem(0);
        setVert(0, 8'd0, 32'd0);
        setVert(1, 8'd0, 32'd5);
        setVert(2, 8'd0, 32'd3);
        setVert(3, 8'd0, INF_W);
        amem[0][1] = 32'd5;
        amem[0][2] = 32'd3;
        amem[2][1] = 32'd2;
        amem[1][2] = 32'h7fffffff;
        amem[3][0] = 32'h80000000;
        runAndCollect(-1, 0, 0, 200);
        checkOutput("nocyc_found", cycle_found, 1'b0);
        checkOutput("nocyc_done", done, 1'b1);
        checkOutput("nocyc_error", error, 1'b0);
        checkOutput("nocyc_valid_seen", saw_valid, 1'b0);

        $display("[TB] three-vertex negative cycle");
        loadCycleGraph(0);
        runAndCollect(-1, 0, 0, 300);
        checkCycleRun("cyc");

        $display("[TB] cycle with 5-cycle stall on beat 2 and a stray start");
        runAndCollect(1, 5, 1, 300);
        checkCycleRun("stall");

        $display("[TB] corrupt predecessor chain");
        loadCycleGraph(1);
        runAndCollect(-1, 0, 0, 300);
        checkOutput("corrupt_beats", nbeats, 4);
        checkOutput("corrupt_v0", beat_v[0], 8'd5);
        checkOutput("corrupt_v1", beat_v[1], 8'd6);
        checkOutput("corrupt_v2", beat_v[2], 8'd7);
        checkOutput("corrupt_v3", beat_v[3], 8'd8);
        checkOutput("corrupt_lasts", {beat_last[0], beat_last[1], beat_last[2], beat_last[3]}, 4'b0000);
        checkOutput("corrupt_error", error, 1'b1);
        checkOutput("corrupt_done", done, 1'b1);
        checkOutput("corrupt_len", cycle_len, 9'd4);

        $display("[TB] reset during emit");
        loadCycleGraph(0);
        applyStimulus();
        reached = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (out_valid) begin
                reached = 1;
                break;
            end
        end
        checkOutput("rstmid_reach_emit", reached, 1'b1);
        cycle_reset = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_valid", out_valid, 1'b0);
        checkOutput("rstmid_done", done, 1'b0);
        checkOutput("rstmid_found", cycle_found, 1'b0);
        checkOutput("rstmid_addr_b", vertmat_addr_b, 8'd0);
        cycle_reset = 1'b0;
        runAndCollect(-1, 0, 0, 300);
        checkCycleRun("rerun");

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
